// File: rtl/uart_rx_cmd_parser_if.sv
// Byte-stream input and command handshake bundle for uart_rx_cmd_parser.
// master = UART receiver / system controller side, slave = the parser.
interface uart_rx_cmd_parser_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_par_err;
  logic              rx_stp_err;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_wdata;
  logic [7:0]        cmd_op_a;
  logic [7:0]        cmd_op_b;
  logic [3:0]        cmd_fun;
  logic              frame_err;
  logic              unk_err;
  logic              ovr_err;

  modport master (
    output rx_data, rx_valid, rx_par_err, rx_stp_err, cmd_ready,
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b,
           cmd_fun, frame_err, unk_err, ovr_err
  );

  modport slave (
    input  rx_data, rx_valid, rx_par_err, rx_stp_err, cmd_ready,
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata, cmd_op_a, cmd_op_b,
           cmd_fun, frame_err, unk_err, ovr_err
  );
endinterface

// File: rtl/uart_rx_cmd_parser.sv
// Assembles UART bytes into command frames and issues them over valid/ready.
// Optional inter-byte timeout compiled in with `define UART_RX_CMD_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for an opcode byte
// W_ADDR   | write frame, expecting address
// W_DATA   | write frame, expecting data
// R_ADDR   | read frame, expecting address
// A_OPA    | ALU frame, expecting operand A
// A_OPB    | ALU frame, expecting operand B
// A_FUN    | ALU frame, expecting function
// N_FUN    | operand-less ALU frame, expecting function
// ISSUE    | command held on cmd_* until accepted
module uart_rx_cmd_parser #(
  parameter int                ADDR_W = 4,
  parameter int                TO_W   = 16,
  parameter logic [TO_W-1:0]   TO_CYC = 16'd5000
) (
  input logic                  clk,
  input logic                  rst,
  uart_rx_cmd_parser_if.slave  io
);

  typedef enum logic [3:0] {
    S_IDLE, S_W_ADDR, S_W_DATA, S_R_ADDR,
    S_A_OPA, S_A_OPB, S_A_FUN, S_N_FUN, S_ISSUE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_cmd_valid, w_cmd_valid_nxt;
  logic [1:0]        r_cmd_type, w_cmd_type_nxt;
  logic [ADDR_W-1:0] r_cmd_addr, w_cmd_addr_nxt;
  logic [7:0]        r_cmd_wdata, w_cmd_wdata_nxt;
  logic [7:0]        r_cmd_op_a, w_cmd_op_a_nxt;
  logic [7:0]        r_cmd_op_b, w_cmd_op_b_nxt;
  logic [3:0]        r_cmd_fun, w_cmd_fun_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              r_unk_err, w_unk_err_nxt;
  logic              r_ovr_err, w_ovr_err_nxt;
  logic              w_take_op;
  logic              w_err;
  logic              w_to_hit;

  assign w_err = io.rx_par_err | io.rx_stp_err;

`ifdef UART_RX_CMD_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            w_collect;

  assign w_collect = (r_state != S_IDLE) && (r_state != S_ISSUE);
  assign w_to_hit  = w_collect && (r_to_cnt == TO_CYC - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (io.rx_valid || w_state_nxt == S_IDLE || w_state_nxt == S_ISSUE) begin
      r_to_cnt <= '0;
    end else if (w_collect) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_to_unused;
  assign w_to_unused = ^TO_CYC;
  assign w_to_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= '0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_op_a  <= '0;
      r_cmd_op_b  <= '0;
      r_cmd_fun   <= '0;
      r_frame_err <= 1'b0;
      r_unk_err   <= 1'b0;
      r_ovr_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_type  <= w_cmd_type_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
      r_cmd_op_a  <= w_cmd_op_a_nxt;
      r_cmd_op_b  <= w_cmd_op_b_nxt;
      r_cmd_fun   <= w_cmd_fun_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_unk_err   <= w_unk_err_nxt;
      r_ovr_err   <= w_ovr_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_type_nxt  = r_cmd_type;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_wdata_nxt = r_cmd_wdata;
    w_cmd_op_a_nxt  = r_cmd_op_a;
    w_cmd_op_b_nxt  = r_cmd_op_b;
    w_cmd_fun_nxt   = r_cmd_fun;
    w_frame_err_nxt = 1'b0;
    w_unk_err_nxt   = 1'b0;
    w_ovr_err_nxt   = 1'b0;
    w_take_op       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_err)            w_frame_err_nxt = 1'b1;
        else if (io.rx_valid) w_take_op       = 1'b1;
      end
      S_ISSUE: begin
        // Handshake cycle doubles as an IDLE cycle so back-to-back frames lose nothing.
        if (io.cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
          w_take_op       = io.rx_valid;
        end else if (io.rx_valid) begin
          w_ovr_err_nxt = 1'b1;
        end
      end
      default: begin
        if (w_err || w_to_hit) begin
          w_state_nxt     = S_IDLE;
          w_frame_err_nxt = 1'b1;
        end else if (io.rx_valid) begin
          case (r_state)
            S_W_ADDR: begin
              w_cmd_addr_nxt = io.rx_data[ADDR_W-1:0];
              w_state_nxt    = S_W_DATA;
            end
            S_W_DATA: begin
              w_cmd_wdata_nxt = io.rx_data;
              w_cmd_valid_nxt = 1'b1;
              w_state_nxt     = S_ISSUE;
            end
            S_R_ADDR: begin
              w_cmd_addr_nxt  = io.rx_data[ADDR_W-1:0];
              w_cmd_valid_nxt = 1'b1;
              w_state_nxt     = S_ISSUE;
            end
            S_A_OPA: begin
              w_cmd_op_a_nxt = io.rx_data;
              w_state_nxt    = S_A_OPB;
            end
            S_A_OPB: begin
              w_cmd_op_b_nxt = io.rx_data;
              w_state_nxt    = S_A_FUN;
            end
            default: begin
              w_cmd_fun_nxt   = io.rx_data[3:0];
              w_cmd_valid_nxt = 1'b1;
              w_state_nxt     = S_ISSUE;
            end
          endcase
        end
      end
    endcase

    if (w_take_op) begin
      case (io.rx_data)
        8'hAA: begin w_cmd_type_nxt = 2'b00; w_state_nxt = S_W_ADDR; end
        8'hBB: begin w_cmd_type_nxt = 2'b01; w_state_nxt = S_R_ADDR; end
        8'hCC: begin w_cmd_type_nxt = 2'b10; w_state_nxt = S_A_OPA;  end
        8'hDD: begin w_cmd_type_nxt = 2'b11; w_state_nxt = S_N_FUN;  end
        default: w_unk_err_nxt = 1'b1;
      endcase
    end
  end

  assign io.cmd_valid = r_cmd_valid;
  assign io.cmd_type  = r_cmd_type;
  assign io.cmd_addr  = r_cmd_addr;
  assign io.cmd_wdata = r_cmd_wdata;
  assign io.cmd_op_a  = r_cmd_op_a;
  assign io.cmd_op_b  = r_cmd_op_b;
  assign io.cmd_fun   = r_cmd_fun;
  assign io.frame_err = r_frame_err;
  assign io.unk_err   = r_unk_err;
  assign io.ovr_err   = r_ovr_err;

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Self-checking bench for uart_rx_cmd_parser: directed vector table, corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_uart_rx_cmd_parser;

  localparam int TO_CYC_TB = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_cmd_parser_if #(.ADDR_W(4)) bus ();

  uart_rx_cmd_parser #(.ADDR_W(4), .TO_W(16), .TO_CYC(16'd20)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        pe, se, rdy;
    logic        e_vld;
    logic [63:0] e_cmd;
    logic        e_fe, e_ue, e_oe;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] pk(logic [1:0] t, logic [3:0] a, logic [7:0] w,
                                     logic [7:0] oa, logic [7:0] ob, logic [3:0] f);
    return {30'd0, t, a, w, oa, ob, f};
  endfunction

  function automatic logic [63:0] dut_cmd();
    return pk(bus.cmd_type, bus.cmd_addr, bus.cmd_wdata, bus.cmd_op_a, bus.cmd_op_b, bus.cmd_fun);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] d, logic pe, logic se, logic rdy);
    bus.rx_valid   = v;
    bus.rx_data    = d;
    bus.rx_par_err = pe;
    bus.rx_stp_err = se;
    bus.cmd_ready  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(string tag, logic vld, logic fe, logic ue, logic oe);
    chk({tag, ".cmd_valid"}, 64'(bus.cmd_valid), 64'(vld));
    chk({tag, ".frame_err"}, 64'(bus.frame_err), 64'(fe));
    chk({tag, ".unk_err"},   64'(bus.unk_err),   64'(ue));
    chk({tag, ".ovr_err"},   64'(bus.ovr_err),   64'(oe));
  endtask

  task automatic add(logic v, logic [7:0] d, logic pe, logic se, logic rdy,
                     logic e_vld, logic [63:0] e_cmd, logic e_fe, logic e_ue, logic e_oe);
    vec_t r;
    r.v = v; r.d = d; r.pe = pe; r.se = se; r.rdy = rdy;
    r.e_vld = e_vld; r.e_cmd = e_cmd; r.e_fe = e_fe; r.e_ue = e_ue; r.e_oe = e_oe;
    tbl.push_back(r);
  endtask

  // Reference model: frame bytes collected so far plus the pending command.
  byte unsigned m_frame[$];
  bit           m_pend;
  logic [1:0]   m_type;
  logic [3:0]   m_addr, m_fun;
  logic [7:0]   m_wd, m_a, m_b;
  logic         m_fe, m_ue, m_oe;
  int           m_since;

  function automatic int frame_len(logic [7:0] op);
    case (op)
      8'hAA:   return 3;
      8'hBB:   return 2;
      8'hCC:   return 4;
      8'hDD:   return 2;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_frame.delete();
    m_pend = 0; m_type = 0; m_addr = 0; m_fun = 0; m_wd = 0; m_a = 0; m_b = 0;
    m_fe = 0; m_ue = 0; m_oe = 0; m_since = 0;
  endtask

  task automatic model_step(logic v, logic [7:0] d, logic pe, logic se, logic rdy);
    bit start = 0;
    bit tmo = 0;
    int pos;
`ifdef UART_RX_CMD_TIMEOUT_EN
    tmo = (m_since == TO_CYC_TB - 1);
`endif
    m_fe = 0; m_ue = 0; m_oe = 0;
    if (m_pend) begin
      if (rdy) begin m_pend = 0; start = v; end
      else if (v) m_oe = 1;
    end else if (m_frame.size() == 0) begin
      if (pe || se) m_fe = 1;
      else start = v;
    end else begin
      if (pe || se || tmo) begin
        m_frame.delete();
        m_fe = 1;
      end else if (v) begin
        m_frame.push_back(d);
        pos = m_frame.size() - 1;
        m_since = 0;
        case (m_frame[0])
          8'hAA: if (pos == 1) m_addr = d[3:0]; else m_wd = d;
          8'hBB: m_addr = d[3:0];
          8'hCC: if (pos == 1) m_a = d; else if (pos == 2) m_b = d; else m_fun = d[3:0];
          default: m_fun = d[3:0];
        endcase
        if (m_frame.size() == frame_len(m_frame[0])) begin
          m_pend = 1;
          m_frame.delete();
        end
      end else begin
        m_since++;
      end
    end
    if (start) begin
      if (frame_len(d) != 0) begin
        m_frame.delete();
        m_frame.push_back(d);
        m_since = 0;
        case (d)
          8'hAA:   m_type = 2'b00;
          8'hBB:   m_type = 2'b01;
          8'hCC:   m_type = 2'b10;
          default: m_type = 2'b11;
        endcase
      end else begin
        m_ue = 1;
      end
    end
  endtask

  initial begin
    logic [63:0] cmd_cc;

    // reset state
    drive(0, 8'h00, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk_flags("reset", 0, 0, 0, 0);
    chk("reset.cmd", dut_cmd(), 64'd0);
    rst = 1'b0;

    // directed vector table, starting from the reset state
    add(1, 8'hAA, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'h05, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'h3C, 0, 0, 1,  1, pk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0), 0, 0, 0);
    add(0, 8'h00, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'hBB, 0, 0, 0,  0, 64'd0, 0, 0, 0);
    add(1, 8'h0F, 0, 0, 0,  1, pk(2'd1, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h0), 0, 0, 0);
    add(1, 8'h77, 0, 0, 0,  1, pk(2'd1, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h0), 0, 0, 1);
    add(0, 8'h00, 0, 0, 0,  1, pk(2'd1, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h0), 0, 0, 0);
    add(1, 8'hDD, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'h08, 0, 0, 1,  1, pk(2'd3, 4'hF, 8'h3C, 8'h00, 8'h00, 4'h8), 0, 0, 0);
    add(0, 8'h00, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'hAA, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'h05, 0, 1, 1,  0, 64'd0, 1, 0, 0);
    add(1, 8'hBB, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'h02, 0, 0, 1,  1, pk(2'd1, 4'h2, 8'h3C, 8'h00, 8'h00, 4'h8), 0, 0, 0);
    add(0, 8'h00, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'h55, 0, 0, 1,  0, 64'd0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 1,  0, 64'd0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1,  0, 64'd0, 1, 0, 0);
    add(1, 8'hDD, 0, 0, 0,  0, 64'd0, 0, 0, 0);
    add(1, 8'h03, 0, 0, 0,  1, pk(2'd3, 4'h2, 8'h3C, 8'h00, 8'h00, 4'h3), 0, 0, 0);
    add(0, 8'h00, 1, 0, 0,  1, pk(2'd3, 4'h2, 8'h3C, 8'h00, 8'h00, 4'h3), 0, 0, 0);
    add(0, 8'h00, 0, 1, 1,  0, 64'd0, 0, 0, 0);
    add(1, 8'hBB, 0, 0, 0,  0, 64'd0, 0, 0, 0);
    add(1, 8'h07, 0, 0, 0,  1, pk(2'd1, 4'h7, 8'h3C, 8'h00, 8'h00, 4'h3), 0, 0, 0);
    add(1, 8'h12, 0, 0, 1,  0, 64'd0, 0, 1, 0);
    add(0, 8'h00, 0, 0, 0,  0, 64'd0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i].v, tbl[i].d, tbl[i].pe, tbl[i].se, tbl[i].rdy);
      chk_flags(tag, tbl[i].e_vld, tbl[i].e_fe, tbl[i].e_ue, tbl[i].e_oe);
      if (tbl[i].e_vld) chk({tag, ".cmd"}, dut_cmd(), tbl[i].e_cmd);
    end

    // ALU frame held for 10 stalled cycles, released by ready
    cmd_cc = pk(2'd2, 4'h7, 8'h3C, 8'h12, 8'h34, 4'h1);
    drive(1, 8'hCC, 0, 0, 0);
    drive(1, 8'h12, 0, 0, 0);
    drive(1, 8'h34, 0, 0, 0);
    drive(1, 8'h01, 0, 0, 0);
    chk_flags("alu_issue", 1, 0, 0, 0);
    chk("alu_issue.cmd", dut_cmd(), cmd_cc);
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h00, 0, 0, 0);
      chk(.nm($sformatf("alu_stall%0d.vld", i)), .act(64'(bus.cmd_valid)), .exp(64'd1));
      chk(.nm($sformatf("alu_stall%0d.cmd", i)), .act(dut_cmd()), .exp(cmd_cc));
    end
    drive(0, 8'h00, 0, 0, 1);
    chk_flags("alu_release", 0, 0, 0, 0);

    // reset in the middle of a frame
    drive(1, 8'hCC, 0, 0, 0);
    drive(1, 8'h11, 0, 0, 0);
    rst = 1'b1;
    drive(1, 8'h22, 0, 0, 0);
    rst = 1'b0;
    chk_flags("midrst", 0, 0, 0, 0);
    chk("midrst.cmd", dut_cmd(), 64'd0);
    drive(1, 8'hAA, 0, 0, 1);
    drive(1, 8'h03, 0, 0, 1);
    drive(1, 8'h99, 0, 0, 1);
    chk_flags("post_rst", 1, 0, 0, 0);
    chk("post_rst.cmd", dut_cmd(), pk(2'd0, 4'h3, 8'h99, 8'h00, 8'h00, 4'h0));
    drive(0, 8'h00, 0, 0, 1);
    chk_flags("post_rst_done", 0, 0, 0, 0);

    // inter-byte gap behaviour
    drive(1, 8'hAA, 0, 0, 1);
`ifdef UART_RX_CMD_TIMEOUT_EN
    for (int i = 0; i < TO_CYC_TB - 1; i++) drive(0, 8'h00, 0, 0, 1);
    chk("to_before.frame_err", 64'(bus.frame_err), 64'd0);
    drive(0, 8'h00, 0, 0, 1);
    chk_flags("to_hit", 0, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 1);
    chk("to_once.frame_err", 64'(bus.frame_err), 64'd0);
    drive(1, 8'h3C, 0, 0, 1);
    chk_flags("to_late_byte", 0, 0, 1, 0);
`else
    for (int i = 0; i < 3 * TO_CYC_TB; i++) drive(0, 8'h00, 0, 0, 1);
    chk_flags("no_to_wait", 0, 0, 0, 0);
    drive(1, 8'h03, 0, 0, 1);
    drive(1, 8'h44, 0, 0, 1);
    chk_flags("no_to_done", 1, 0, 0, 0);
    chk("no_to_done.cmd", dut_cmd(), pk(2'd0, 4'h3, 8'h44, 8'h00, 8'h00, 4'h0));
`endif

    // randomized traffic against the reference model
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      logic       v, pe, se, rdy;
      logic [7:0] d;
      logic [7:0] ops [4];
      ops[0] = 8'hAA; ops[1] = 8'hBB; ops[2] = 8'hCC; ops[3] = 8'hDD;
      v   = ($urandom_range(2) == 0);
      d   = ($urandom_range(1) == 0) ? ops[$urandom_range(3)] : 8'($urandom);
      pe  = ($urandom_range(24) == 0);
      se  = ($urandom_range(24) == 0);
      rdy = ($urandom_range(2) != 0);
      model_step(v, d, pe, se, rdy);
      drive(v, d, pe, se, rdy);
      chk_flags($sformatf("rnd%0d", i), m_pend, m_fe, m_ue, m_oe);
      chk($sformatf("rnd%0d.cmd", i), dut_cmd(), pk(m_type, m_addr, m_wd, m_a, m_b, m_fun));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd_parser.md
Name: uart_rx_cmd_parser

Overview:
- Sits directly downstream of the UART receiver.
- Consumes its byte stream (data byte plus valid and error strobes) and assembles multi-byte command frames.
- Presents each complete frame as one registered command to the system controller through a valid/ready handshake.
- Aborts frames that contain errors or undefined opcodes, and flags any byte that arrives while a command is stalled.

Parameters:
- ADDR_W, 4, register-file address width; the address byte is truncated to its low ADDR_W bits.
- TO_W, 16, width of the inter-byte timeout counter (used only when the optional feature is compiled in).
- TO_CYC, 16'd5000, inter-byte timeout in clk cycles (used only when the optional feature is compiled in).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- rx_data  in  8  received byte; qualified by rx_valid.
- rx_valid  in  1  one-cycle strobe: rx_data holds a good byte.
- rx_par_err  in  1  one-cycle strobe: parity error on the current byte.
- rx_stp_err  in  1  one-cycle strobe: stop-bit error on the current byte.
- cmd_valid  out  1  a command is held on the cmd_* outputs.
- cmd_ready  in  1  downstream accepts the command this cycle.
- cmd_type  out  2  00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
- cmd_addr  out  ADDR_W  register address (types 00 and 01).
- cmd_wdata  out  8  write data (type 00).
- cmd_op_a  out  8  ALU operand A (type 10).
- cmd_op_b  out  8  ALU operand B (type 10).
- cmd_fun  out  4  ALU function, rx_data[3:0] of the function byte (types 10 and 11).
- frame_err  out  1  one-cycle pulse: frame aborted by a parity or stop error.
- unk_err  out  1  one-cycle pulse: undefined opcode received in IDLE.
- ovr_err  out  1  one-cycle pulse: byte dropped while in ISSUE.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; every output is 0, including all cmd_* fields. Reset mid-frame or mid-ISSUE discards everything with no error pulse.
- Opcodes accepted in IDLE:
  - 0xAA: write, frame AA, addr, data.
  - 0xBB: read, frame BB, addr.
  - 0xCC: ALU with operands, frame CC, A, B, fun.
  - 0xDD: ALU without operands, frame DD, fun.
- Any other byte in IDLE pulses unk_err for one cycle; state stays IDLE.
- FSM states: IDLE, W_ADDR, W_DATA, R_ADDR, A_OPA, A_OPB, A_FUN, N_FUN, ISSUE.
- Each rx_valid advances one state along the chosen frame path. The field byte is captured into its cmd_* register on the same edge.
- The final byte of a frame moves the FSM to ISSUE. cmd_valid rises on the edge after that byte's rx_valid (latency 1 cycle). cmd_type is set at opcode capture.
- ISSUE: cmd_valid and all cmd_* outputs stay stable until cmd_valid&cmd_ready. On that edge cmd_valid falls and state returns to IDLE.
- Same cycle as the handshake:
  - rx_valid is processed as an IDLE opcode (zero bubble), so a valid opcode moves directly to its first field state.
  - An error strobe is ignored.
- ISSUE without cmd_ready:
  - rx_valid drops the byte and pulses ovr_err.
  - Error strobes are ignored.
- Error strobes in any non-IDLE collecting state: rx_par_err|rx_stp_err abort the frame → IDLE, pulse frame_err once. This takes priority over a simultaneous rx_valid.
- Error strobes in IDLE: frame_err pulses; state stays IDLE.
- cmd_* fields not used by the current type keep their previous values; they are don't-care downstream.
- Error pulses are registered, high for exactly one cycle per event. frame_err, unk_err and ovr_err are never set by the same event.

Optional Feature:
- Macro: UART_RX_CMD_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on every rx_valid and on entry to IDLE or ISSUE.
  - It increments every cycle in a collecting state (any state except IDLE and ISSUE).
  - On reaching TO_CYC-1 the frame aborts → IDLE and frame_err pulses. Any rx_valid that cycle is ignored.
- Undefined: no counter exists; a partial frame waits indefinitely.

Test Plan:
- AA,05,3C with cmd_ready=1 → cmd_valid one cycle after 3C's strobe; type=00, addr=5, wdata=0x3C; returns to IDLE.
- CC,12,34,01 with cmd_ready held low 10 cycles → outputs stable for those 10 cycles (type=10, op_a=0x12, op_b=0x34, fun=1); clears one cycle after ready rises.
- BB,0F while ready=0, then byte 0x77 → ovr_err pulses once, command unchanged. Then ready=1 together with DD strobe → handshake completes, FSM moves to N_FUN; fun 0x08 → type=11, fun=8.
- AA then rx_stp_err on the address byte → frame_err one pulse, no cmd_valid. Following BB,02 → normal read with addr=2.
- Byte 0x55 in IDLE → unk_err one pulse, state IDLE. rst asserted mid CC frame → all outputs 0, the next frame parses cleanly.
- With UART_RX_CMD_TIMEOUT_EN and TO_CYC=20: send AA, then idle 20 cycles → frame_err pulse; a late data byte is then treated as an opcode in IDLE.
